// File: rtl/rbus_d2r_arb_pkg.sv
// rbus_d2r_arb_pkg: shared constants for the ring-bus d2r packet arbiter
// Contents: FSM state encodings, default packet length, default grant timeout, beat width.
package rbus_d2r_arb_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_PASS  = 2'd2;
    localparam int BEAT_W       = 72;
    localparam int PKT_LEN_DEF  = 9;
    localparam int GRANT_TO_DEF = 15;
endpackage

// File: rtl/rbus_d2r_arb_rr_pick.sv
// rbus_rr_pick: combinational N-way round-robin picker
// Ports: req (per-source request), ptr (highest-priority index),
//        gnt_idx (first requester at or after ptr, circular), gnt_vld (any request).
module rbus_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_vld
);
    // Scan from the farthest candidate back to ptr so the nearest requester wins last.
    always_comb begin
        int j;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        j = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                gnt_idx = PW'(j);
                gnt_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rbus_d2r_arb.sv
// rbus_d2r_arb: packet-granular round-robin arbiter sharing one ring-bus d2r egress port
// Ports: clk, rst (async, active-high); src_req/src_stb/src_sof/src_data (per source,
//        72-bit beats packed by index); src_rdy (2 bits per source: [1] grant, [0] d2r_rdy[0]);
//        d2r_stb/d2r_sof/d2r_data (registered egress); d2r_rdy (ring ready); err (sticky).
// Option: define RBUS_D2R_ARB_GRANT_TO_EN to abandon a grant after GRANT_TO cycles without sof.
module rbus_d2r_arb
    import rbus_d2r_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int PKT_LEN  = PKT_LEN_DEF,
    parameter int GRANT_TO = GRANT_TO_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        src_req,
    input  logic [N-1:0]        src_stb,
    input  logic [N-1:0]        src_sof,
    input  logic [BEAT_W*N-1:0] src_data,
    output logic [2*N-1:0]      src_rdy,
    output logic                d2r_stb,
    output logic                d2r_sof,
    output logic [BEAT_W-1:0]   d2r_data,
    input  logic [1:0]          d2r_rdy,
    output logic                err
);
    localparam int PW = $clog2(N);

    if (N < 2 || N > 8) $error("rbus_d2r_arb: N must be 2..8");
    if (PKT_LEN < 2 || PKT_LEN > 15) $error("rbus_d2r_arb: PKT_LEN must be 2..15");
    if (GRANT_TO < 1 || GRANT_TO > 255) $error("rbus_d2r_arb: GRANT_TO must be 1..255");

    logic [1:0]    state;
    logic [PW-1:0] ptr, w, w_nxt, gnt_idx;
    logic [3:0]    beat_cnt;
    logic          gnt_vld, w_stb, w_sof, fwd, eop, stray, tmo, err_set;

    rbus_rr_pick #(.N(N), .PW(PW)) u_pick (
        .req     (src_req),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign w_stb = src_stb[w];
    assign w_sof = src_sof[w];
    assign w_nxt = (w == PW'(N - 1)) ? '0 : w + PW'(1);
    assign fwd   = (state == ST_GRANT && w_stb && w_sof) || (state == ST_PASS && w_stb);
    assign eop   = state == ST_PASS && w_stb && !w_sof && beat_cnt + 4'd1 == 4'(PKT_LEN);
    // Outside a grant every strobe is stray; during one, only the winner may strobe.
    assign stray = (state == ST_IDLE) ? |src_stb : |(src_stb & ~(N'(1) << w));
    assign err_set = stray | tmo | (state == ST_GRANT && w_stb && !w_sof)
                   | (state == ST_PASS && w_stb && w_sof);

    // The pass-through bits are held low during reset so every output reads 0 in reset.
    always_comb begin
        src_rdy = '0;
        for (int i = 0; i < N; i++) begin
            src_rdy[2*i]   = d2r_rdy[0] & ~rst;
            src_rdy[2*i+1] = state == ST_GRANT && w == PW'(i) && d2r_rdy[1];
        end
    end

`ifdef RBUS_D2R_ARB_GRANT_TO_EN
    logic [7:0] tmr;
    // Reloaded every IDLE cycle, so it holds GRANT_TO on entry to GRANT.
    assign tmo = state == ST_GRANT && tmr == 8'd1 && !(w_stb && w_sof);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmr <= '0;
        else if (state == ST_IDLE) tmr <= 8'(GRANT_TO);
        else if (state == ST_GRANT) tmr <= tmr - 8'd1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            w        <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
            d2r_stb  <= 1'b0;
            d2r_sof  <= 1'b0;
            d2r_data <= '0;
        end else begin
            d2r_stb  <= fwd;
            d2r_sof  <= fwd & w_sof;
            d2r_data <= fwd ? src_data[BEAT_W*w +: BEAT_W] : '0;
            err      <= err | err_set;
            case (state)
                ST_GRANT: begin
                    if (w_stb && w_sof) begin
                        state    <= ST_PASS;
                        beat_cnt <= 4'd1;
                    end else if (!src_req[w] || tmo) begin
                        state <= ST_IDLE;
                        ptr   <= w_nxt;
                    end
                end
                ST_PASS: begin
                    if (w_stb) beat_cnt <= w_sof ? 4'd1 : beat_cnt + 4'd1;
                    if (eop) begin
                        state <= ST_IDLE;
                        ptr   <= w_nxt;
                    end
                end
                default: begin
                    if (d2r_rdy[1] && gnt_vld) begin
                        w     <= gnt_idx;
                        state <= ST_GRANT;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rbus_d2r_arb.sv
// tb_rbus_d2r_arb: scoreboard bench for the ring-bus d2r packet arbiter
module tb_rbus_d2r_arb;
    localparam int N = 4;
    localparam int W = 72;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   src_req = '0;
    logic [N-1:0]   src_stb = '0;
    logic [N-1:0]   src_sof = '0;
    logic [W*N-1:0] src_data = '0;
    logic [2*N-1:0] src_rdy;
    logic           d2r_stb, d2r_sof;
    logic [W-1:0]   d2r_data;
    logic [1:0]     d2r_rdy = 2'b00;
    logic           err;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic         sof;
        logic [W-1:0] data;
    } beat_t;
    beat_t exp_q[$];

    rbus_d2r_arb #(.N(N), .PKT_LEN(9), .GRANT_TO(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .src_req  (src_req),
        .src_stb  (src_stb),
        .src_sof  (src_sof),
        .src_data (src_data),
        .src_rdy  (src_rdy),
        .d2r_stb  (d2r_stb),
        .d2r_sof  (d2r_sof),
        .d2r_data (d2r_data),
        .d2r_rdy  (d2r_rdy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every egress beat must match the head of the expected queue.
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (d2r_stb) begin
                if (exp_q.size() == 0) begin
                    chk("d2r_stb_unexpected", W'(d2r_stb), '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("d2r_sof", W'(d2r_sof), W'(e.sof));
                    chk("d2r_data", d2r_data, e.data);
                end
            end else begin
                chk("d2r_idle_sof", W'(d2r_sof), '0);
                chk("d2r_idle_data", d2r_data, '0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int c = 0; c < 50 && g < 0; c++) begin
            for (int i = 0; i < N; i++) if (src_rdy[2*i+1]) g = i;
            if (g < 0) step();
        end
    endtask

    task automatic drive_beat(input int s, input logic [7:0] tag, input int b, input bit push);
        beat_t e;
        e.sof  = (b == 0);
        e.data = {tag, 8'(b), 56'(s)};
        src_stb[s] = 1'b1;
        src_sof[s] = e.sof;
        src_data[W*s +: W] = e.data;
        if (push) exp_q.push_back(e);
    endtask

    task automatic clear_src(input int s);
        src_stb[s] = 1'b0;
        src_sof[s] = 1'b0;
        src_data[W*s +: W] = '0;
    endtask

    task automatic send(input int s, input logic [7:0] tag, input int intr);
        for (int b = 0; b < 9; b++) begin
            drive_beat(s, tag, b, 1'b1);
            if (b == 3 && intr >= 0) begin
                src_stb[intr] = 1'b1;
                src_data[W*intr +: W] = {8'hEE, 64'h0};
            end
            step();
            if (intr >= 0) clear_src(intr);
        end
        clear_src(s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int cnt;
        step();
        d2r_rdy = 2'b11;
        #1;
        chk("rst_d2r_stb", W'(d2r_stb), '0);
        chk("rst_d2r_sof", W'(d2r_sof), '0);
        chk("rst_d2r_data", d2r_data, '0);
        chk("rst_src_rdy", W'(src_rdy), '0);
        chk("rst_err", W'(err), '0);
        step();
        d2r_rdy = 2'b10;
        rst = 1'b0;

        src_req = '1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            chk("rr_grant", W'(g), W'(k % N));
            chk("rr_rdy_vec", W'(src_rdy), W'(8'd1 << (2 * (k % N) + 1)));
            send(g < 0 ? 0 : g, 8'h10 + 8'(k), -1);
            chk("rr_gap", W'(src_rdy), '0);
        end
        src_req = '0;

        d2r_rdy = 2'b01;
        src_req[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("nrdy_src_rdy", W'(src_rdy), W'(8'h55));
        end
        d2r_rdy = 2'b10;
        step();
        chk("nrdy_grant", W'(src_rdy), W'(8'h02));
        send(0, 8'h20, -1);
        src_req[0] = 1'b0;
        chk("single_err", W'(err), '0);

        src_req[1] = 1'b1;
        wait_grant(g);
        chk("intr_grant", W'(g), W'(1));
        send(1, 8'h30, 2);
        src_req[1] = 1'b0;
        chk("intr_err", W'(err), W'(1));

        src_req[2] = 1'b1;
        wait_grant(g);
        chk("mid_grant", W'(g), W'(2));
        for (int b = 0; b < 5; b++) begin
            drive_beat(2, 8'h40, b, b < 4);
            step();
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_d2r_stb", W'(d2r_stb), '0);
        chk("mid_rst_d2r_data", d2r_data, '0);
        chk("mid_rst_src_rdy", W'(src_rdy), '0);
        chk("mid_rst_err", W'(err), '0);
        clear_src(2);
        src_req = '0;
        step();
        rst = 1'b0;
        src_req = 4'b1010;
        step();
        chk("post_rst_ptr0", W'(src_rdy), W'(8'h08));
        src_req = '0;
        step();
        chk("req_drop_idle", W'(src_rdy), '0);
        chk("req_drop_err", W'(err), '0);

`ifdef RBUS_D2R_ARB_GRANT_TO_EN
        src_req = 4'b1001;
        wait_grant(g);
        chk("to_grant", W'(g), W'(3));
        cnt = 0;
        while (src_rdy[7] && cnt < 40) begin
            cnt++;
            step();
        end
        chk("to_cycles", W'(cnt), W'(15));
        chk("to_err", W'(err), W'(1));
        wait_grant(g);
        chk("to_next", W'(g), W'(0));
        src_req = '0;
        step();
`else
        src_req[3] = 1'b1;
        wait_grant(g);
        chk("hold_grant", W'(g), W'(3));
        cnt = 0;
        repeat (20) step();
        chk("hold_rdy", W'(src_rdy), W'(8'h80));
        chk("hold_err", W'(err), '0);
        src_req = '0;
        step();
        chk("hold_release", W'(src_rdy), '0);
`endif

        repeat (3) step();
        chk("queue_empty", W'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
